alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
Downstream consumer of the calendar/time-of-day counter block.
- Compares the live hour, minute, second and week outputs against a programmed alarm with a weekday mask.
- Runs a ring/snooze/stop state machine and drives a square-wave buzzer.
- Runs on the system clock and advances its second-based counters on the same one-second tick that advances the time block.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (1..60)
RING_TIMEOUT_S, 60, seconds of unattended ringing before auto-stop (1..255)
BEEP_DIV, 25000, clk cycles per buzzer half-period (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
sec_tick  input  1  one-cycle pulse per second, the same event that advances the time block
cur_hour  input  11  current hour from time block
cur_minute  input  11  current minute
cur_second  input  11  current second
cur_week  input  11  current weekday, 1..7
set_en  input  1  one-cycle alarm-programming strobe
set_hour  input  5  new alarm hour, 0..23
set_minute  input  6  new alarm minute, 0..59
set_week_mask  input  7  bit n enables weekday n+1
alarm_enable  input  1  level; 0 disarms the alarm
btn_snooze  input  1  one-cycle pulse, already synchronised and debounced
btn_stop  input  1  one-cycle pulse, already synchronised and debounced
buzzer  output  1  square wave while ringing, 0 otherwise
ringing  output  1  state==RINGING
snoozing  output  1  state==SNOOZE
alarm_hour  output  5  programmed hour
alarm_minute  output  6  programmed minute
alarm_week_mask  output  7  programmed mask

Behaviour:
- Reset (async, immediate): state IDLE; alarm_hour 7, alarm_minute 0, alarm_week_mask 7'b0011111; all counters 0; buzzer, ringing, snoozing 0.
- Programming:
  - On set_en with set_hour<=23 and set_minute<=59, all three alarm registers load on that edge.
  - Out-of-range values reject the whole write; registers are unchanged.
  - An accepted or rejected write while RINGING or SNOOZE forces IDLE.
- Match condition (evaluated only on sec_tick edges, against cur_* sampled at that edge):
  - alarm_enable=1, cur_hour==alarm_hour, cur_minute==alarm_minute, cur_second==0, and cur_week in 1..7 with alarm_week_mask[cur_week-1]=1.
  - cur_week of 0 or >7, or cur_second>=60, never matches.
- FSM (Moore outputs, registered, visible the cycle after the transition edge):
  - IDLE -> RINGING on match; ring counter cleared.
  - RINGING:
    - ring counter increments on each sec_tick.
    - btn_stop -> IDLE.
    - else btn_snooze -> SNOOZE, snooze counter loaded with SNOOZE_MIN*60.
    - else ring counter reaching RING_TIMEOUT_S -> IDLE.
    - A new match while RINGING is ignored.
  - SNOOZE:
    - snooze counter decrements on sec_tick.
    - Transition to RINGING on the tick that takes it 1 -> 0; ring counter cleared.
    - btn_stop -> IDLE.
    - btn_snooze is ignored.
  - Any state: alarm_enable=0 -> IDLE on the next edge; this has highest priority after reset.
- Priority on the same edge: rst > alarm_enable=0 > set_en > btn_stop > btn_snooze > timeout/expiry > match.
- Buzzer:
  - Divider counts clk cycles 0..BEEP_DIV-1 and toggles buzzer at wrap.
  - Divider and buzzer are held at 0 outside RINGING and restart from 0 on each entry to RINGING.
  - First rising edge of buzzer occurs BEEP_DIV cycles after ringing rises.
- Widths: snooze counter 12 bits; ring counter 8 bits; beep divider $clog2(BEEP_DIV) bits. No counter wraps because FSM exits are taken first.

Decomposition:
- Shared package clock_pkg holds:
  - alarm_state_t enum {IDLE, RINGING, SNOOZE}
  - constants MAX_HOUR=23, MAX_MINUTE=59, SECS_PER_MIN=60, DAYS_PER_WEEK=7
  - reset defaults for alarm time and mask
- One sub-module, beep_gen (enable, BEEP_DIV divider, square-wave out), instantiated once.

Test Plan:
- Reset defaults, cur=07:00:00, week=3, sec_tick -> ringing=1 next cycle; buzzer rises BEEP_DIV cycles later.
- Same time with week=6 (mask bit5=0) -> stays IDLE. Then set_en 06:30, mask 7'h7F; present week=6 06:30:00 -> ringing.
- Ringing, btn_snooze, SNOOZE_MIN=1 -> snoozing=1, buzzer=0. Exactly 60 sec_ticks later ringing=1; btn_stop -> IDLE.
- Ringing, no buttons, RING_TIMEOUT_S=60 -> auto IDLE on the 60th sec_tick. btn_stop and btn_snooze on the same edge -> IDLE, not SNOOZE.
- set_en with hour=24 -> registers unchanged (alarm_hour stays 7); set_en while SNOOZE -> IDLE.
- rst asserted mid-RINGING between clk edges -> ringing and buzzer 0 immediately; alarm registers back to 07:00 and 7'b0011111.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared alarm types, limits and reset defaults
//
// Purpose : Holds the alarm FSM state type, the calendar limits and the
//           alarm register reset values used by alarm_ctrl.
// Ports   : none (package)
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam int unsigned MAX_HOUR      = 23;
  localparam int unsigned MAX_MINUTE    = 59;
  localparam int unsigned SECS_PER_MIN  = 60;
  localparam int unsigned DAYS_PER_WEEK = 7;

  localparam logic [4:0] RST_ALARM_HOUR   = 5'd7;
  localparam logic [5:0] RST_ALARM_MINUTE = 6'd0;
  localparam logic [6:0] RST_WEEK_MASK    = 7'b0011111;

  // Weekdays are numbered 1..7; anything else never matches.
  function automatic logic week_match(input logic [6:0] mask, input logic [10:0] week);
    logic hit;
    hit = 1'b0;
    if (week >= 11'd1 && week <= 11'(DAYS_PER_WEEK)) begin
      hit = mask[week[2:0] - 3'd1];
    end
    return hit;
  endfunction

endpackage

// File: rtl/alarm_ctrl_beep_gen.sv
// rtl/alarm_ctrl_beep_gen.sv - square-wave buzzer divider
//
// Purpose : While en_i is high, counts clk cycles 0..BEEP_DIV-1 and toggles
//           the output on each wrap. Held at 0 while en_i is low, so every
//           enable starts a fresh waveform.
// Ports   : clk, rst (async, active-high), en_i (run), beep_o (square wave)
module beep_gen #(
  parameter int unsigned BEEP_DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic beep_o
);

  localparam int unsigned W = $clog2(BEEP_DIV);

  logic [W-1:0] cnt_q, cnt_d;
  logic         beep_q, beep_d;
  logic         wrap;

  assign wrap = (cnt_q == W'(BEEP_DIV - 1));

  always_comb begin
    cnt_d  = '0;
    beep_d = 1'b0;
    if (en_i) begin
      cnt_d  = wrap ? '0 : cnt_q + W'(1);
      beep_d = wrap ? ~beep_q : beep_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beep_q <= beep_d;
    end
  end

  // Gate with the enable so the buzzer drops in the same cycle ringing does.
  assign beep_o = beep_q & en_i;

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm compare, ring/snooze/stop FSM and buzzer
//
// Purpose : Compares live time-of-day against a programmed alarm with a
//           weekday mask, runs the ring/snooze/stop state machine and drives
//           a square-wave buzzer while ringing.
// Ports   : clk, rst (async, active-high), sec_tick (1 Hz pulse),
//           cur_hour/minute/second/week (live time), set_en/set_hour/
//           set_minute/set_week_mask (alarm programming), alarm_enable,
//           btn_snooze, btn_stop, buzzer, ringing, snoozing,
//           alarm_hour/alarm_minute/alarm_week_mask (programmed alarm).
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned BEEP_DIV       = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  input  logic [10:0] cur_week,
  input  logic        set_en,
  input  logic [4:0]  set_hour,
  input  logic [5:0]  set_minute,
  input  logic [6:0]  set_week_mask,
  input  logic        alarm_enable,
  input  logic        btn_snooze,
  input  logic        btn_stop,
  output logic        buzzer,
  output logic        ringing,
  output logic        snoozing,
  output logic [4:0]  alarm_hour,
  output logic [5:0]  alarm_minute,
  output logic [6:0]  alarm_week_mask
);

  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * SECS_PER_MIN);
  localparam logic [7:0]  RING_LIMIT  = 8'(RING_TIMEOUT_S);

  alarm_state_t state_q, state_d;
  logic [7:0]   ring_cnt_q, ring_cnt_d;
  logic [11:0]  snooze_cnt_q, snooze_cnt_d;
  logic [4:0]   alarm_hour_q, alarm_hour_d;
  logic [5:0]   alarm_minute_q, alarm_minute_d;
  logic [6:0]   alarm_mask_q, alarm_mask_d;

  logic       set_ok;
  logic       match;
  logic [7:0] ring_cnt_inc;

  assign set_ok = (set_hour <= 5'(MAX_HOUR)) && (set_minute <= 6'(MAX_MINUTE));

  // Only second 0 of the programmed minute can fire, so one alarm per day.
  assign match = sec_tick && alarm_enable
              && (cur_hour   == {6'd0, alarm_hour_q})
              && (cur_minute == {5'd0, alarm_minute_q})
              && (cur_second == 11'd0)
              && week_match(alarm_mask_q, cur_week);

  assign ring_cnt_inc = ring_cnt_q + 8'd1;

  always_comb begin
    alarm_hour_d   = alarm_hour_q;
    alarm_minute_d = alarm_minute_q;
    alarm_mask_d   = alarm_mask_q;
    if (set_en && set_ok) begin
      alarm_hour_d   = set_hour;
      alarm_minute_d = set_minute;
      alarm_mask_d   = set_week_mask;
    end
  end

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!alarm_enable || set_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        RINGING: begin
          if (sec_tick) ring_cnt_d = ring_cnt_inc;
          if (btn_stop) begin
            state_d = IDLE;
          end else if (btn_snooze) begin
            state_d      = SNOOZE;
            snooze_cnt_d = SNOOZE_LOAD;
          end else if (sec_tick && ring_cnt_inc == RING_LIMIT) begin
            state_d = IDLE;
          end
        end
        SNOOZE: begin
          if (sec_tick) snooze_cnt_d = snooze_cnt_q - 12'd1;
          if (btn_stop) begin
            state_d = IDLE;
          end else if (sec_tick && snooze_cnt_q == 12'd1) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ring_cnt_q     <= 8'd0;
      snooze_cnt_q   <= 12'd0;
      alarm_hour_q   <= RST_ALARM_HOUR;
      alarm_minute_q <= RST_ALARM_MINUTE;
      alarm_mask_q   <= RST_WEEK_MASK;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snooze_cnt_q   <= snooze_cnt_d;
      alarm_hour_q   <= alarm_hour_d;
      alarm_minute_q <= alarm_minute_d;
      alarm_mask_q   <= alarm_mask_d;
    end
  end

  beep_gen #(
    .BEEP_DIV(BEEP_DIV)
  ) u_beep_gen (
    .clk   (clk),
    .rst   (rst),
    .en_i  (ringing),
    .beep_o(buzzer)
  );

  assign ringing         = (state_q == RINGING);
  assign snoozing        = (state_q == SNOOZE);
  assign alarm_hour      = alarm_hour_q;
  assign alarm_minute    = alarm_minute_q;
  assign alarm_week_mask = alarm_mask_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed self-checking bench for alarm_ctrl
module tb_alarm_ctrl;

  localparam int unsigned BEEP_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sec_tick;
  logic [10:0] cur_hour, cur_minute, cur_second, cur_week;
  logic        set_en;
  logic [4:0]  set_hour;
  logic [5:0]  set_minute;
  logic [6:0]  set_week_mask;
  logic        alarm_enable;
  logic        btn_snooze, btn_stop;
  logic        buzzer, ringing, snoozing;
  logic [4:0]  alarm_hour;
  logic [5:0]  alarm_minute;
  logic [6:0]  alarm_week_mask;

  int checks = 0;
  int errors = 0;

  alarm_ctrl #(
    .SNOOZE_MIN    (1),
    .RING_TIMEOUT_S(60),
    .BEEP_DIV      (BEEP_DIV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sec_tick       (sec_tick),
    .cur_hour       (cur_hour),
    .cur_minute     (cur_minute),
    .cur_second     (cur_second),
    .cur_week       (cur_week),
    .set_en         (set_en),
    .set_hour       (set_hour),
    .set_minute     (set_minute),
    .set_week_mask  (set_week_mask),
    .alarm_enable   (alarm_enable),
    .btn_snooze     (btn_snooze),
    .btn_stop       (btn_stop),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozing       (snoozing),
    .alarm_hour     (alarm_hour),
    .alarm_minute   (alarm_minute),
    .alarm_week_mask(alarm_week_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s, input int w);
    cur_hour   = 11'(h);
    cur_minute = 11'(m);
    cur_second = 11'(s);
    cur_week   = 11'(w);
  endtask

  task automatic program_alarm(input int h, input int m, input logic [6:0] mask);
    set_hour      = 5'(h);
    set_minute    = 6'(m);
    set_week_mask = mask;
    set_en        = 1'b1;
    cycle();
    set_en        = 1'b0;
  endtask

  task automatic press_stop();
    btn_stop = 1'b1;
    cycle();
    btn_stop = 1'b0;
  endtask

  task automatic press_snooze();
    btn_snooze = 1'b1;
    cycle();
    btn_snooze = 1'b0;
  endtask

  // Fire the alarm at the given time, then move off second 0 so later
  // ticks in IDLE cannot re-trigger it.
  task automatic fire(input int h, input int m, input int w);
    set_time(h, m, 0, w);
    tick();
    cur_second = 11'd1;
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; set_en = 1'b0;
    set_hour = '0; set_minute = '0; set_week_mask = '0;
    alarm_enable = 1'b0; btn_snooze = 1'b0; btn_stop = 1'b0;
    set_time(0, 0, 1, 1);
    cycle(); cycle();
    check("rst_ringing", 32'(ringing), 32'd0);
    check("rst_snoozing", 32'(snoozing), 32'd0);
    check("rst_buzzer", 32'(buzzer), 32'd0);
    check("rst_hour", 32'(alarm_hour), 32'd7);
    check("rst_minute", 32'(alarm_minute), 32'd0);
    check("rst_mask", 32'(alarm_week_mask), 32'h1F);
    rst = 1'b0;
    alarm_enable = 1'b1;
    cycle();

    // Default alarm 07:00 on weekday 3; buzzer rises BEEP_DIV cycles later.
    fire(7, 0, 3);
    check("match_ringing", 32'(ringing), 32'd1);
    check("buzz_start", 32'(buzzer), 32'd0);
    for (int i = 1; i < BEEP_DIV; i++) cycle();
    check("buzz_before_rise", 32'(buzzer), 32'd0);
    cycle();
    check("buzz_rise", 32'(buzzer), 32'd1);
    press_stop();
    check("stop_ringing", 32'(ringing), 32'd0);
    check("stop_buzzer", 32'(buzzer), 32'd0);

    // Masked weekday and invalid weekdays never match.
    fire(7, 0, 6);
    check("week6_masked", 32'(ringing), 32'd0);
    fire(7, 0, 0);
    check("week0_nomatch", 32'(ringing), 32'd0);
    fire(7, 0, 8);
    check("week8_nomatch", 32'(ringing), 32'd0);
    set_time(7, 0, 60, 3);
    tick();
    check("sec60_nomatch", 32'(ringing), 32'd0);
    cur_second = 11'd1;

    // Reprogram to 06:30 every day.
    program_alarm(6, 30, 7'h7F);
    check("set_hour", 32'(alarm_hour), 32'd6);
    check("set_minute", 32'(alarm_minute), 32'd30);
    check("set_mask", 32'(alarm_week_mask), 32'h7F);
    fire(6, 30, 6);
    check("week6_ringing", 32'(ringing), 32'd1);

    // Snooze for one minute; a second snooze press is ignored.
    press_snooze();
    check("snooze_state", 32'(snoozing), 32'd1);
    check("snooze_ringing", 32'(ringing), 32'd0);
    check("snooze_buzzer", 32'(buzzer), 32'd0);
    press_snooze();
    check("snooze_again", 32'(snoozing), 32'd1);
    for (int i = 0; i < 59; i++) tick();
    check("snooze_59", 32'(snoozing), 32'd1);
    tick();
    check("snooze_expire_ring", 32'(ringing), 32'd1);
    check("snooze_expire_snz", 32'(snoozing), 32'd0);
    press_stop();
    check("snooze_stop", 32'(ringing), 32'd0);

    // Unattended ringing stops on the 60th tick.
    fire(6, 30, 2);
    check("timeout_enter", 32'(ringing), 32'd1);
    for (int i = 0; i < 59; i++) tick();
    check("timeout_59", 32'(ringing), 32'd1);
    tick();
    check("timeout_60", 32'(ringing), 32'd0);

    // Stop beats snooze on the same edge.
    fire(6, 30, 2);
    btn_stop = 1'b1; btn_snooze = 1'b1;
    cycle();
    btn_stop = 1'b0; btn_snooze = 1'b0;
    check("both_ringing", 32'(ringing), 32'd0);
    check("both_snoozing", 32'(snoozing), 32'd0);

    // Disarming forces IDLE and suppresses matches.
    fire(6, 30, 2);
    alarm_enable = 1'b0;
    cycle();
    check("disarm_idle", 32'(ringing), 32'd0);
    fire(6, 30, 2);
    check("disarm_nomatch", 32'(ringing), 32'd0);
    alarm_enable = 1'b1;

    // Out-of-range writes are rejected whole.
    program_alarm(24, 15, 7'h01);
    check("rej_hour_h", 32'(alarm_hour), 32'd6);
    check("rej_hour_m", 32'(alarm_minute), 32'd30);
    check("rej_hour_mask", 32'(alarm_week_mask), 32'h7F);
    program_alarm(5, 60, 7'h01);
    check("rej_min_h", 32'(alarm_hour), 32'd6);

    // Any write during SNOOZE returns to IDLE.
    fire(6, 30, 4);
    press_snooze();
    check("pre_set_snooze", 32'(snoozing), 32'd1);
    program_alarm(8, 15, 7'h7F);
    check("set_in_snooze", 32'(snoozing), 32'd0);
    check("set_in_snooze_ring", 32'(ringing), 32'd0);
    check("set_in_snooze_h", 32'(alarm_hour), 32'd8);

    // Async reset mid-ring, weekday 7 boundary.
    fire(8, 15, 7);
    check("week7_ringing", 32'(ringing), 32'd1);
    for (int i = 0; i < BEEP_DIV; i++) cycle();
    check("pre_rst_buzzer", 32'(buzzer), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_ringing", 32'(ringing), 32'd0);
    check("async_buzzer", 32'(buzzer), 32'd0);
    check("async_hour", 32'(alarm_hour), 32'd7);
    check("async_minute", 32'(alarm_minute), 32'd0);
    check("async_mask", 32'(alarm_week_mask), 32'h1F);
    cycle();
    rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
